shot_clock_counter: RTL

- Countdown core of the 24-second shot clock.
- Divides the system clock into 0.1 s ticks and counts down from a full (24 s) or short (14 s) reload.
- Handles start/pause and expiry, and drives the expiry buzzer.
- Sits directly upstream of seven_seg and feeds its 16-bit display_value with whole seconds remaining, rounded up.

---
 rtl/shot_clock_pkg.sv | 21 ++
 rtl/shot_clock_counter_tick_gen.sv | 33 +++
 rtl/shot_clock_counter.sv | 119 +++++++++++
 3 files changed

// File: rtl/shot_clock_pkg.sv
// Shared types and constants for the shot clock countdown core.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package shot_clock_pkg;

    // Countdown FSM states.
    typedef enum logic [1:0] {
        STOP    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    // Tenths counter width: holds up to 51 s * 10 = 510.
    localparam int TENTHS_W = 9;

    // System clocks per countdown tick.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/shot_clock_counter_tick_gen.sv
// Prescaler: divides clk into one-cycle tick pulses every DIV enabled cycles.
// Latency: tick is combinational from the registered count; first tick DIV enabled cycles after clear.
// Backpressure: none; en low freezes the count so the sub-tick phase survives a pause.
//
// Ports: clk, rst (sync, active-high), en (count enable), clr (restart phase at 0),
//        tick (high for the one cycle the count sits at DIV-1 while enabled).
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Gated by en so a count paused at DIV-1 does not emit repeated ticks.
    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/shot_clock_counter.sv
// Shot clock countdown: tenths-of-a-second countdown with start/pause, reloads, expiry and buzzer.
// Latency: controls act on the next cycle; display_value follows the registered tenths combinationally.
// Backpressure: none; pulses are consumed immediately, lower-priority pulses in the same cycle are dropped.
//
// Ports: clk, rst (sync, active-high), start_pause / reload_full / reload_short (one-cycle pulses),
//        display_value (whole seconds remaining, rounded up), running, expired, buzzer.
module shot_clock_counter
    import shot_clock_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 10,
    parameter int FULL_SEC   = 24,
    parameter int SHORT_SEC  = 14,
    parameter int BUZZ_TICKS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_pause,
    input  logic        reload_full,
    input  logic        reload_short,
    output logic [15:0] display_value,
    output logic        running,
    output logic        expired,
    output logic        buzzer
);

    localparam int DIV    = calc_div(CLK_HZ, TICK_HZ);
    localparam int BUZZ_W = $clog2(BUZZ_TICKS + 1);

    localparam logic [TENTHS_W-1:0] FULL_T    = TENTHS_W'(FULL_SEC * 10);
    localparam logic [TENTHS_W-1:0] SHORT_T   = TENTHS_W'(SHORT_SEC * 10);
    localparam logic [BUZZ_W-1:0]   BUZZ_LOAD = BUZZ_W'(BUZZ_TICKS);

    state_t              state_q, state_d;
    logic [TENTHS_W-1:0] tenths_q, tenths_d;
    logic [BUZZ_W-1:0]   buzz_cnt_q, buzz_cnt_d;
    logic                buzzer_q, buzzer_d;
    logic                reload, presc_en, tick;
    logic [TENTHS_W:0]   rounded;

    assign reload   = reload_full || reload_short;
    // Prescaler also runs during the buzzer so the buzz duration is measured in ticks.
    assign presc_en = (state_q == RUN) || ((state_q == EXPIRED) && buzzer_q);

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en),
        .clr  (reload),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        tenths_d   = tenths_q;
        buzz_cnt_d = buzz_cnt_q;
        buzzer_d   = buzzer_q;

        if (reload) begin
            // Reloads outrank everything else, including an expiring tick.
            tenths_d = reload_full ? FULL_T : SHORT_T;
            if (state_q == EXPIRED) begin
                state_d    = STOP;
                buzz_cnt_d = '0;
                buzzer_d   = 1'b0;
            end
        end else begin
            unique case (state_q)
                STOP: begin
                    if (start_pause) state_d = RUN;
                end
                RUN: begin
                    if (tick && (tenths_q <= TENTHS_W'(1))) begin
                        tenths_d   = '0;
                        state_d    = EXPIRED;
                        buzz_cnt_d = BUZZ_LOAD;
                        buzzer_d   = 1'b1;
                    end else begin
                        // A tick landing with a pause still counts, so no time is lost.
                        if (tick) tenths_d = tenths_q - TENTHS_W'(1);
                        if (start_pause) state_d = STOP;
                    end
                end
                EXPIRED: begin
                    // Buzzer register mirrors "counter not yet zero".
                    if (tick && buzzer_q) begin
                        buzz_cnt_d = buzz_cnt_q - BUZZ_W'(1);
                        buzzer_d   = (buzz_cnt_q != BUZZ_W'(1));
                    end
                end
                default: state_d = STOP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= STOP;
            tenths_q   <= FULL_T;
            buzz_cnt_q <= '0;
            buzzer_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tenths_q   <= tenths_d;
            buzz_cnt_q <= buzz_cnt_d;
            buzzer_q   <= buzzer_d;
        end
    end

    // Seconds rounded up; one extra bit so FULL_SEC up to 51 cannot overflow the +9.
    assign rounded       = {1'b0, tenths_q} + (TENTHS_W + 1)'(9);
    assign display_value = 16'(rounded / (TENTHS_W + 1)'(10));
    assign running       = (state_q == RUN);
    assign expired       = (state_q == EXPIRED);
    assign buzzer        = buzzer_q;

endmodule
